// File: rtl/rf_scoreboard_ctrl_pkg.sv
// rtl/rf_scoreboard_ctrl_pkg.sv - shared constants and FSM encoding for the register scoreboard
package rf_scoreboard_ctrl_pkg;

    localparam int REG_COUNT  = 32;
    localparam int REG_IDX_W  = 5;
    localparam int CNT_W      = 2;
    localparam int INFLIGHT_W = 7;

    localparam logic [CNT_W-1:0] CNT_MAX = 2'd3;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/sb_counter.sv
// rtl/sb_counter.sv - saturating 2-bit up/down pending-write counter for one register
module sb_counter
    import rf_scoreboard_ctrl_pkg::*;
(
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o,
    output logic             full_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Simultaneous inc and dec cancel, so the count holds.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);
    assign full_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/rf_scoreboard_ctrl.sv
// rtl/rf_scoreboard_ctrl.sv - register-file write scoreboard with issue interlock and drain FSM
module rf_scoreboard_ctrl
    import rf_scoreboard_ctrl_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  IssueValid,
    output logic                  IssueReady,
    input  logic [REG_IDX_W-1:0]  IssueSrc1,
    input  logic [REG_IDX_W-1:0]  IssueSrc2,
    input  logic                  IssueDstValid,
    input  logic [REG_IDX_W-1:0]  IssueDst,
    input  logic                  WbValid,
    input  logic [REG_IDX_W-1:0]  WbReg,
    output logic                  RfWriteEnable,
    output logic [REG_IDX_W-1:0]  RfWriteSelect,
    input  logic                  DrainReq,
    output logic                  DrainDone,
    output logic [INFLIGHT_W-1:0] InFlight,
    output logic                  WbError
);

    logic [1:0]            state_q, state_d;
    logic                  wb_error_q, wb_error_d;
    logic [REG_COUNT-1:0]  zero_w, full_w, inc_w, dec_w;
    logic [CNT_W-1:0]      cnt_w [REG_COUNT];
    logic                  issue_fire, issue_inc, wb_hit, wb_miss, rf_wr;
    logic [INFLIGHT_W-1:0] in_flight_sum, in_flight_next;

    // r0 is hard-wired as never pending and never full.
    assign zero_w[0] = 1'b1;
    assign full_w[0] = 1'b0;
    assign cnt_w[0]  = '0;

    for (genvar r = 1; r < REG_COUNT; r++) begin : g_cnt
        sb_counter u_cnt (
            .clk_i    (Clk),
            .resetn_i (Reset),
            .inc_i    (inc_w[r]),
            .dec_i    (dec_w[r]),
            .cnt_o    (cnt_w[r]),
            .zero_o   (zero_w[r]),
            .full_o   (full_w[r])
        );
    end

    // Sources look at pre-update counts, so a same-cycle writeback is not bypassed.
    assign IssueReady = (state_q == ST_RUN) && zero_w[IssueSrc1] && zero_w[IssueSrc2] &&
                        !(IssueDstValid && full_w[IssueDst]);

    assign issue_fire    = IssueValid && IssueReady;
    assign issue_inc     = issue_fire && IssueDstValid && (IssueDst != '0);
    assign rf_wr         = WbValid && (WbReg != '0);
    assign wb_hit        = rf_wr && !zero_w[WbReg];
    assign wb_miss       = rf_wr && zero_w[WbReg];
    assign RfWriteEnable = rf_wr;
    assign RfWriteSelect = WbReg;

    always_comb begin
        inc_w = '0;
        dec_w = '0;
        if (issue_inc) begin
            inc_w[IssueDst] = 1'b1;
        end
        if (wb_hit) begin
            dec_w[WbReg] = 1'b1;
        end
    end

    always_comb begin
        in_flight_sum = '0;
        for (int r = 1; r < REG_COUNT; r++) begin
            in_flight_sum = in_flight_sum + INFLIGHT_W'(cnt_w[r]);
        end
    end

    assign InFlight       = in_flight_sum;
    assign in_flight_next = in_flight_sum + INFLIGHT_W'(issue_inc) - INFLIGHT_W'(wb_hit);
    assign DrainDone      = (state_q == ST_DONE);

    always_comb begin
        state_d    = state_q;
        wb_error_d = wb_error_q || wb_miss;
        case (state_q)
            ST_RUN:   if (DrainReq) state_d = ST_DRAIN;
            ST_DRAIN: if (in_flight_next == '0) state_d = ST_DONE;
            ST_DONE:  state_d = DrainReq ? ST_DRAIN : ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q    <= ST_RUN;
            wb_error_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wb_error_q <= wb_error_d;
        end
    end

    assign WbError = wb_error_q;

endmodule

// File: tb/tb_rf_scoreboard_ctrl.sv
// tb/tb_rf_scoreboard_ctrl.sv - scoreboard bench for rf_scoreboard_ctrl
module tb_rf_scoreboard_ctrl;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       IssueValid, IssueDstValid, WbValid, DrainReq;
    logic [4:0] IssueSrc1, IssueSrc2, IssueDst, WbReg;
    logic       IssueReady, RfWriteEnable, DrainDone, WbError;
    logic [4:0] RfWriteSelect;
    logic [6:0] InFlight;

    int errors = 0;
    int checks = 0;

    int cnt_m [32];
    int st_m;
    bit err_m;

    typedef struct {
        bit ready;
        bit we;
        int sel;
        int inf;
        bit dd;
        bit err;
    } exp_t;

    exp_t sbq [$];

    rf_scoreboard_ctrl dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .IssueValid    (IssueValid),
        .IssueReady    (IssueReady),
        .IssueSrc1     (IssueSrc1),
        .IssueSrc2     (IssueSrc2),
        .IssueDstValid (IssueDstValid),
        .IssueDst      (IssueDst),
        .WbValid       (WbValid),
        .WbReg         (WbReg),
        .RfWriteEnable (RfWriteEnable),
        .RfWriteSelect (RfWriteSelect),
        .DrainReq      (DrainReq),
        .DrainDone     (DrainDone),
        .InFlight      (InFlight),
        .WbError       (WbError)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int m_inflight();
        int s = 0;
        for (int r = 1; r < 32; r++) s += cnt_m[r];
        return s;
    endfunction

    function automatic bit m_ready();
        bit p1 = (IssueSrc1 != 0) && (cnt_m[IssueSrc1] != 0);
        bit p2 = (IssueSrc2 != 0) && (cnt_m[IssueSrc2] != 0);
        bit df = IssueDstValid && (IssueDst != 0) && (cnt_m[IssueDst] == 3);
        return (st_m == 0) && !p1 && !p2 && !df;
    endfunction

    task automatic m_update();
        if (!Reset) begin
            for (int r = 0; r < 32; r++) cnt_m[r] = 0;
            st_m  = 0;
            err_m = 0;
        end else begin
            bit fire = IssueValid && m_ready();
            bit inc  = fire && IssueDstValid && (IssueDst != 0);
            bit wbv  = WbValid && (WbReg != 0) && (cnt_m[WbReg] != 0);
            if (WbValid && (WbReg != 0) && (cnt_m[WbReg] == 0)) err_m = 1;
            if (inc) cnt_m[IssueDst]++;
            if (wbv) cnt_m[WbReg]--;
            case (st_m)
                0: if (DrainReq) st_m = 1;
                1: if (m_inflight() == 0) st_m = 2;
                default: st_m = DrainReq ? 1 : 0;
            endcase
        end
    endtask

    task automatic tick();
        exp_t e;
        @(negedge Clk);
        if (Reset) begin
            e.ready = m_ready();
            e.we    = WbValid && (WbReg != 0);
            e.sel   = WbReg;
            e.inf   = m_inflight();
            e.dd    = (st_m == 2);
            e.err   = err_m;
            sbq.push_back(e);
            e = sbq.pop_front();
            check_eq("sb_ready", IssueReady, e.ready);
            check_eq("sb_rf_we", RfWriteEnable, e.we);
            check_eq("sb_rf_sel", RfWriteSelect, e.sel);
            check_eq("sb_inflight", InFlight, e.inf);
            check_eq("sb_drain_done", DrainDone, e.dd);
            check_eq("sb_wb_error", WbError, e.err);
        end
        @(posedge Clk);
        m_update();
        #1;
    endtask

    task automatic drive(input bit iv, input int s1, input int s2, input bit dv, input int dst,
                         input bit wv, input int wr, input bit dr);
        IssueValid    = iv;
        IssueSrc1     = 5'(s1);
        IssueSrc2     = 5'(s2);
        IssueDstValid = dv;
        IssueDst      = 5'(dst);
        WbValid       = wv;
        WbReg         = 5'(wr);
        DrainReq      = dr;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        Reset = 1'b0;
        idle();
        tick();
        tick();
        Reset = 1'b1;
        #1;
        check_eq("rst_inflight", InFlight, 0);
        check_eq("rst_ready", IssueReady, 1);
        check_eq("rst_wb_error", WbError, 0);
        check_eq("rst_drain_done", DrainDone, 0);

        // RAW hazard on r5 cleared by its writeback
        drive(1, 0, 0, 1, 5, 0, 0, 0); tick();
        drive(1, 5, 0, 0, 0, 1, 5, 0); #1;
        check_eq("raw_ready_blocked", IssueReady, 0);
        check_eq("raw_rf_we", RfWriteEnable, 1);
        check_eq("raw_rf_sel", RfWriteSelect, 5);
        tick();
        drive(1, 5, 0, 0, 0, 0, 0, 0); #1;
        check_eq("raw_ready_after_wb", IssueReady, 1);
        tick();

        // saturate r7 and confirm no same-cycle bypass
        drive(1, 0, 0, 1, 7, 0, 0, 0);
        tick(); tick(); tick();
        check_eq("sat_inflight", InFlight, 3);
        check_eq("sat_ready_full", IssueReady, 0);
        drive(1, 0, 0, 1, 7, 1, 7, 0); #1;
        check_eq("sat_ready_no_bypass", IssueReady, 0);
        tick();
        idle(); #1;
        check_eq("sat_inflight_after_wb", InFlight, 2);
        drive(0, 0, 0, 0, 0, 1, 7, 0); tick(); tick();

        // issue and writeback to r9 in the same cycle
        drive(1, 0, 0, 1, 9, 0, 0, 0); tick();
        drive(1, 0, 0, 1, 9, 1, 9, 0); #1;
        check_eq("same_ready", IssueReady, 1);
        tick();
        idle(); #1;
        check_eq("same_inflight", InFlight, 1);
        drive(0, 0, 0, 0, 0, 1, 9, 0); tick();

        // drain with two outstanding writes
        drive(1, 0, 0, 1, 10, 0, 0, 0); tick();
        drive(1, 0, 0, 1, 11, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1); tick();
        idle(); #1;
        check_eq("drain_ready_blocked", IssueReady, 0);
        check_eq("drain_not_done", DrainDone, 0);
        drive(0, 0, 0, 0, 0, 1, 10, 0); tick();
        check_eq("drain_ready_mid", IssueReady, 0);
        check_eq("drain_not_done_mid", DrainDone, 0);
        drive(0, 0, 0, 0, 0, 1, 11, 0); tick();
        idle(); #1;
        check_eq("drain_done_pulse", DrainDone, 1);
        check_eq("drain_done_ready", IssueReady, 0);
        tick();
        check_eq("drain_done_cleared", DrainDone, 0);
        check_eq("drain_back_run", IssueReady, 1);

        // r0 writeback is ignored, then a spurious r12 writeback is sticky
        drive(0, 0, 0, 0, 0, 1, 0, 0); #1;
        check_eq("wb_r0_we", RfWriteEnable, 0);
        tick();
        check_eq("wb_r0_no_error", WbError, 0);
        drive(0, 0, 0, 0, 0, 1, 12, 0); tick();
        idle(); #1;
        check_eq("wb_error_set", WbError, 1);
        tick();
        check_eq("wb_error_sticky", WbError, 1);

        // reset mid-drain abandons outstanding writes
        Reset = 1'b0; tick();
        Reset = 1'b1;
        drive(1, 0, 0, 1, 3, 0, 0, 1); tick();
        Reset = 1'b0; idle(); tick();
        Reset = 1'b1; #1;
        check_eq("mid_rst_inflight", InFlight, 0);
        check_eq("mid_rst_wb_error", WbError, 0);
        tick();
        check_eq("mid_rst_no_done", DrainDone, 0);
        drive(0, 0, 0, 0, 0, 1, 3, 0); tick();
        idle(); #1;
        check_eq("mid_rst_late_wb_error", WbError, 1);

        // randomized traffic checked against the model
        Reset = 1'b0; tick();
        Reset = 1'b1;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7),
                  $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 15) == 0);
            Reset = ($urandom_range(0, 99) != 0);
            tick();
        end
        Reset = 1'b1;
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
